bitwise_logic_pipe: RTL and testbench

BITWISE_LOGIC_PIPE -- requirements
Module: bitwise_logic_pipe

---
 rtl/bitwise_logic_pipe.sv | 136 +++++++++++++
 tb/tb_bitwise_logic_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready pipeline applying one of eight bitwise ops to two operands.
// Optional completed-result counter on done_cnt when BITWISE_LOGIC_CNT_EN is defined.
module bitwise_logic_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             ones,
  output logic             out_valid,
  input  logic             out_ready
`ifdef BITWISE_LOGIC_CNT_EN
  ,
  output logic [15:0]      done_cnt
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_in1_q, s1_in1_d;
  logic [WIDTH-1:0] s1_in2_q, s1_in2_d;
  logic [2:0]       s1_op_q, s1_op_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;

  logic             s2_load;
  logic             in_hs;
  logic [WIDTH-1:0] result;

  // S2 frees up on the same edge it hands off, so a full pipe still streams.
  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;
  assign in_hs    = in_valid & in_ready;

  always_comb begin
    result = '0;
    unique case (s1_op_q)
      3'd0: result = ~(s1_in1_q & s1_in2_q);
      3'd1: result = s1_in1_q & s1_in2_q;
      3'd2: result = s1_in1_q | s1_in2_q;
      3'd3: result = ~(s1_in1_q | s1_in2_q);
      3'd4: result = s1_in1_q ^ s1_in2_q;
      3'd5: result = ~(s1_in1_q ^ s1_in2_q);
      3'd6: result = ~s1_in1_q;
      3'd7: result = s1_in1_q;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_in1_d   = s1_in1_q;
    s1_in2_d   = s1_in2_q;
    s1_op_d    = s1_op_q;
    if (in_hs) begin
      s1_valid_d = 1'b1;
      s1_in1_d   = in1;
      s1_in2_d   = in2;
      s1_op_d    = op;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    zero_d     = zero_q;
    ones_d     = ones_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      out_d      = result;
      zero_d     = (result == '0);
      ones_d     = (result == '1);
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_in1_q   <= '0;
      s1_in2_q   <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      zero_q     <= 1'b1;
      ones_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_in1_q   <= s1_in1_d;
      s1_in2_q   <= s1_in2_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      zero_q     <= zero_d;
      ones_q     <= ones_d;
    end
  end

  assign out       = out_q;
  assign zero      = zero_q;
  assign ones      = ones_q;
  assign out_valid = s2_valid_q;

`ifdef BITWISE_LOGIC_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Wraps naturally at 16 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (s2_valid_q && out_ready) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe: directed scenarios plus random traffic
// checked against an in-order queue model of the pipeline.
module tb_bitwise_logic_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in1, in2;
  logic [2:0]   op;
  logic         in_valid, in_ready;
  logic [W-1:0] out;
  logic         zero, ones, out_valid, out_ready;
`ifdef BITWISE_LOGIC_CNT_EN
  logic [15:0]  done_cnt;
  logic [15:0]  exp_cnt;
`endif

  always #5 clk = ~clk;

  bitwise_logic_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in1      (in1),
    .in2      (in2),
    .op       (op),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .zero     (zero),
    .ones     (ones),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef BITWISE_LOGIC_CNT_EN
    ,
    .done_cnt (done_cnt)
`endif
  );

  typedef struct {
    logic [W-1:0] r;
    int unsigned  edge_idx;
  } item_t;

  item_t        q[$];
  int unsigned  edge_cnt = 0;
  int           n_cmp = 0;
  int           n_fail = 0;
  logic [W-1:0] seen_out[$];
  logic         seen_zero[$];
  logic         seen_ones[$];
  logic         last_in_ready;

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] o);
    case (o)
      3'd0:    return ~(a & b);
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  // One clock cycle: drive, check against the model, then advance the model at the edge.
  task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] o, input logic ordy);
    logic  exp_ir, exp_ov, in_hs, out_hs;
    item_t it;
    @(negedge clk);
    in_valid  = iv;
    in1       = a;
    in2       = b;
    op        = o;
    out_ready = ordy;
    #1;
    exp_ir = (q.size() < 2) || ordy;
    exp_ov = (q.size() > 0) && (q[0].edge_idx + 1 < edge_cnt);
    last_in_ready = in_ready;
    n_cmp++;
    if (in_ready !== exp_ir) begin
      n_fail++;
      $display("FAIL in_ready @%0t: got %b expected %b", $time, in_ready, exp_ir);
    end
    n_cmp++;
    if (out_valid !== exp_ov) begin
      n_fail++;
      $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, exp_ov);
    end
    if (exp_ov) begin
      n_cmp++;
      if (out !== q[0].r || zero !== (q[0].r == '0) || ones !== (q[0].r == '1)) begin
        n_fail++;
        $display("FAIL result @%0t: got out=%h zero=%b ones=%b expected out=%h zero=%b ones=%b",
                 $time, out, zero, ones, q[0].r, q[0].r == '0, q[0].r == '1);
      end
    end
`ifdef BITWISE_LOGIC_CNT_EN
    n_cmp++;
    if (done_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL done_cnt @%0t: got %h expected %h", $time, done_cnt, exp_cnt);
    end
`endif
    if (out_valid === 1'b1 && ordy) begin
      seen_out.push_back(out);
      seen_zero.push_back(zero);
      seen_ones.push_back(ones);
    end
    in_hs  = iv && exp_ir;
    out_hs = exp_ov && ordy;
    @(posedge clk);
    if (out_hs) begin
      void'(q.pop_front());
`ifdef BITWISE_LOGIC_CNT_EN
      exp_cnt++;
`endif
    end
    if (in_hs) begin
      it.r        = ref_op(a, b, o);
      it.edge_idx = edge_cnt;
      q.push_back(it);
    end
    edge_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    q.delete();
    edge_cnt++;
`ifdef BITWISE_LOGIC_CNT_EN
    exp_cnt = 16'd0;
`endif
    #1;
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || out !== '0 || zero !== 1'b1 || ones !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b out=%h zero=%b ones=%b expected 0 00 1 0",
               out_valid, out, zero, ones);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
`ifdef BITWISE_LOGIC_CNT_EN
    n_cmp++;
    if (done_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_done_cnt: got %h expected 0000", done_cnt);
    end
`endif
  endtask

  task automatic clear_seen();
    seen_out.delete();
    seen_zero.delete();
    seen_ones.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in1 = '0;
    in2 = '0;
    op = '0;
`ifdef BITWISE_LOGIC_CNT_EN
    exp_cnt = 16'd0;
`endif
    do_reset();
  endtask

  task automatic test_basic();
    clear_seen();
    step(1'b1, 8'hF0, 8'hFF, 3'd0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    n_cmp++;
    if (seen_out.size() != 1) begin
      n_fail++;
      $display("FAIL basic_count: got %0d results expected 1", seen_out.size());
    end else if (seen_out[0] !== 8'h0F || seen_zero[0] !== 1'b0 || seen_ones[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_nand: got out=%h zero=%b ones=%b expected 0f 0 0",
               seen_out[0], seen_zero[0], seen_ones[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_tab[8];
    exp_tab = '{8'hDB, 8'h24, 8'hBD, 8'h42, 8'h99, 8'h66, 8'h5A, 8'hA5};
    clear_seen();
    for (int i = 0; i < 8; i++) step(1'b1, 8'hA5, 8'h3C, 3'(i), 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    n_cmp++;
    if (seen_out.size() != 8) begin
      n_fail++;
      $display("FAIL sweep_count: got %0d results expected 8", seen_out.size());
    end
    for (int i = 0; i < 8 && i < seen_out.size(); i++) begin
      n_cmp++;
      if (seen_out[i] !== exp_tab[i]) begin
        n_fail++;
        $display("FAIL sweep_op%0d: got %h expected %h", i, seen_out[i], exp_tab[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0);
      n_cmp++;
      if (last_in_ready !== (i < 2)) begin
        n_fail++;
        $display("FAIL stall_in_ready%0d: got %b expected %b", i, last_in_ready, i < 2);
      end
    end
    clear_seen();
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    n_cmp++;
    if (seen_out.size() != 2) begin
      n_fail++;
      $display("FAIL stall_drain: got %0d results expected 2", seen_out.size());
    end
  endtask

  task automatic test_flags();
    clear_seen();
    step(1'b1, 8'h00, 8'($urandom), 3'd1, 1'b1);
    step(1'b1, 8'h00, 8'($urandom), 3'd0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    n_cmp++;
    if (seen_out.size() != 2) begin
      n_fail++;
      $display("FAIL flags_count: got %0d results expected 2", seen_out.size());
    end else if (seen_zero[0] !== 1'b1 || seen_out[1] !== 8'hFF || seen_ones[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL flags: got zero=%b out=%h ones=%b expected 1 ff 1",
               seen_zero[0], seen_out[1], seen_ones[1]);
    end
  endtask

  task automatic test_reset_midflight();
    step(1'b1, 8'h12, 8'h34, 3'd4, 1'b0);
    step(1'b1, 8'h56, 8'h78, 3'd2, 1'b0);
    do_reset();
    clear_seen();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    n_cmp++;
    if (seen_out.size() != 0) begin
      n_fail++;
      $display("FAIL stale_after_reset: got %0d results expected 0", seen_out.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (i % 200 == 199) do_reset();
      step(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom), 3'($urandom),
           ($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
  endtask

`ifdef BITWISE_LOGIC_CNT_EN
  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 65537; i++) step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    #1;
    n_cmp++;
    if (done_cnt !== 16'h0001) begin
      n_fail++;
      $display("FAIL cnt_wrap: got %h expected 0001", done_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_flags();
    test_reset_midflight();
    test_random();
`ifdef BITWISE_LOGIC_CNT_EN
    test_counter_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
